mem_access_sb: RTL and testbench

Next-generation memory-access pipeline stage for the RISC-V core. It adds a parametrised store buffer so that stores retire without waiting for memory. It formats loads by byte lane and sign, detects misaligned accesses, and talks to data memory over a simple single-outstanding req/gnt/rvalid port. It sits between EXE and WB; upstream uses a valid/ready handshake, and WB always accepts.

---
 rtl/mem_access_sb.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_access_sb.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_sb.sv
// Memory-access stage with a store buffer: formats loads, flags misaligned accesses,
// and shares one single-outstanding req/gnt/rvalid port between loads and buffered stores.
module mem_access_sb #(
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32,
    parameter int SB_DEPTH  = 4,
    parameter int NUM_REGS  = 32
) (
    input  logic                        i_aclk,
    input  logic                        i_areset_n,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [1:0]                  i_memop,
    input  logic [1:0]                  i_size,
    input  logic                        i_unsigned,
    input  logic [DATA_SIZE-1:0]        i_exe_out,
    input  logic [DATA_SIZE-1:0]        i_mem_wdata,
    input  logic [$clog2(NUM_REGS)-1:0] i_rdest,
    input  logic                        i_cu_regwrite,
    input  logic [1:0]                  i_cu_memtoreg,
    input  logic [31:0]                 i_pcplus4,
    output logic                        o_valid,
    output logic [$clog2(NUM_REGS)-1:0] o_rdest,
    output logic                        o_cu_regwrite,
    output logic [1:0]                  o_cu_memtoreg,
    output logic [31:0]                 o_pcplus4,
    output logic [DATA_SIZE-1:0]        o_exe_data,
    output logic [DATA_SIZE-1:0]        o_mem_data,
    output logic                        o_exc_misaligned,
    output logic                        o_mem_req,
    output logic                        o_mem_we,
    output logic [ADDR_SIZE-1:0]        o_mem_addr,
    output logic [31:0]                 o_mem_wdata,
    output logic [3:0]                  o_mem_be,
    input  logic                        i_mem_gnt,
    input  logic                        i_mem_rvalid,
    input  logic [31:0]                 i_mem_rdata,
    output logic                        o_sb_empty
);
    localparam int RW = $clog2(NUM_REGS);
    localparam int PW = $clog2(SB_DEPTH);
    localparam int WA = ADDR_SIZE - 2;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} ld_state_t;

    ld_state_t            state_q;
    logic                 valid_q, regwrite_q, exc_q, req_q, we_q, drain_q, ld_uns_q;
    logic [RW-1:0]        rdest_q;
    logic [1:0]           memtoreg_q, ld_off_q, ld_size_q;
    logic [31:0]          pcplus4_q, mwdata_q;
    logic [DATA_SIZE-1:0] exe_q, mem_data_q;
    logic [WA-1:0]        maddr_q;
    logic [3:0]           mbe_q;
    logic [PW:0]          rd_ptr_q, wr_ptr_q;
    logic [WA-1:0]        sb_addr_q [SB_DEPTH];
    logic [31:0]          sb_data_q [SB_DEPTH];
    logic [3:0]           sb_be_q   [SB_DEPTH];

    logic        is_load, is_store, misal, ld_ok, st_ok;
    logic        full, empty, conflict, pop, accept, ld_acc, st_acc, drain_start;
    logic [PW:0] count;
    logic [PW-1:0] rel;
    logic [31:0] st_dat_d, fmt_d;
    logic [3:0]  st_be_d;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign is_load  = (i_memop == 2'b01);
    assign is_store = (i_memop == 2'b10);
    assign misal    = (is_load | is_store) &
                      ((i_size == 2'b11) | ((i_size == 2'b01) & i_exe_out[0]) |
                       ((i_size == 2'b10) & (i_exe_out[1:0] != 2'b00)));
    assign ld_ok    = is_load & ~misal;
    assign st_ok    = is_store & ~misal;

    assign count = wr_ptr_q - rd_ptr_q;
    assign full  = (count == (PW+1)'(SB_DEPTH));
    assign empty = (count == '0);
    assign pop   = drain_q & i_mem_gnt;

    // An entry is live when its distance from the read pointer is below the fill count.
    always_comb begin
        conflict = 1'b0;
        rel      = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            rel = PW'(i) - rd_ptr_q[PW-1:0];
            if (({1'b0, rel} < count) && (sb_addr_q[i] == i_exe_out[ADDR_SIZE-1:2]))
                conflict = 1'b1;
        end
    end

    // A load never preempts a drain already on the bus; a full buffer still takes a store on the pop cycle.
    assign o_ready = (state_q == S_IDLE) &
                     ~(st_ok & full & ~pop) &
                     ~(ld_ok & (conflict | (drain_q & ~i_mem_gnt)));

    assign accept      = i_valid & o_ready;
    assign ld_acc      = accept & ld_ok;
    assign st_acc      = accept & st_ok;
    assign drain_start = (state_q == S_IDLE) & ~ld_acc & ~empty & ~drain_q;

    always_comb begin
        case (i_size)
            2'b00: begin
                st_dat_d = {4{i_mem_wdata[7:0]}};
                st_be_d  = 4'b0001 << i_exe_out[1:0];
            end
            2'b01: begin
                st_dat_d = {2{i_mem_wdata[15:0]}};
                st_be_d  = 4'b0011 << i_exe_out[1:0];
            end
            default: begin
                st_dat_d = i_mem_wdata[31:0];
                st_be_d  = 4'b1111;
            end
        endcase
    end

    always_comb begin
        ld_byte = i_mem_rdata[{ld_off_q, 3'b000} +: 8];
        ld_half = ld_off_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        case (ld_size_q)
            2'b00:   fmt_d = {{24{~ld_uns_q & ld_byte[7]}}, ld_byte};
            2'b01:   fmt_d = {{16{~ld_uns_q & ld_half[15]}}, ld_half};
            default: fmt_d = i_mem_rdata;
        endcase
    end

    always_ff @(posedge i_aclk) begin
        if (st_acc) begin
            sb_addr_q[wr_ptr_q[PW-1:0]] <= i_exe_out[ADDR_SIZE-1:2];
            sb_data_q[wr_ptr_q[PW-1:0]] <= st_dat_d;
            sb_be_q[wr_ptr_q[PW-1:0]]   <= st_be_d;
        end
    end

    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_q    <= S_IDLE;
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            exc_q      <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            drain_q    <= 1'b0;
            ld_uns_q   <= 1'b0;
            rdest_q    <= '0;
            memtoreg_q <= '0;
            ld_off_q   <= '0;
            ld_size_q  <= '0;
            pcplus4_q  <= '0;
            mwdata_q   <= '0;
            exe_q      <= '0;
            mem_data_q <= '0;
            maddr_q    <= '0;
            mbe_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            if (pop) begin
                drain_q  <= 1'b0;
                req_q    <= 1'b0;
                we_q     <= 1'b0;
                rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
            end
            if (drain_start) begin
                drain_q  <= 1'b1;
                req_q    <= 1'b1;
                we_q     <= 1'b1;
                maddr_q  <= sb_addr_q[rd_ptr_q[PW-1:0]];
                mwdata_q <= sb_data_q[rd_ptr_q[PW-1:0]];
                mbe_q    <= sb_be_q[rd_ptr_q[PW-1:0]];
            end
            if (st_acc)
                wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
            case (state_q)
                S_IDLE: if (ld_acc) begin
                    state_q   <= S_REQ;
                    req_q     <= 1'b1;
                    we_q      <= 1'b0;
                    maddr_q   <= i_exe_out[ADDR_SIZE-1:2];
                    mwdata_q  <= '0;
                    mbe_q     <= st_be_d;
                    ld_off_q  <= i_exe_out[1:0];
                    ld_size_q <= i_size;
                    ld_uns_q  <= i_unsigned;
                end
                S_REQ: if (i_mem_gnt) begin
                    state_q <= S_WAIT;
                    req_q   <= 1'b0;
                end
                S_WAIT: if (i_mem_rvalid) begin
                    state_q    <= S_IDLE;
                    mem_data_q <= fmt_d;
                    valid_q    <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
            if (accept) begin
                rdest_q    <= i_rdest;
                memtoreg_q <= i_cu_memtoreg;
                pcplus4_q  <= i_pcplus4;
                exe_q      <= i_exe_out;
                exc_q      <= misal;
                regwrite_q <= i_cu_regwrite & ~misal;
                if (!ld_acc)
                    valid_q <= 1'b1;
            end
        end
    end

    assign o_valid          = valid_q;
    assign o_rdest          = rdest_q;
    assign o_cu_regwrite    = regwrite_q;
    assign o_cu_memtoreg    = memtoreg_q;
    assign o_pcplus4        = pcplus4_q;
    assign o_exe_data       = exe_q;
    assign o_mem_data       = mem_data_q;
    assign o_exc_misaligned = exc_q;
    assign o_mem_req        = req_q;
    assign o_mem_we         = we_q;
    assign o_mem_addr       = {maddr_q, 2'b00};
    assign o_mem_wdata      = mwdata_q;
    assign o_mem_be         = mbe_q;
    assign o_sb_empty       = empty & ~drain_q;
endmodule

// File: tb/tb_mem_access_sb.sv
// Bench for mem_access_sb: vector table plus hand sequences, with WB and memory-write scoreboards.
module tb_mem_access_sb;
    logic        i_aclk = 1'b0;
    logic        i_areset_n;
    logic        i_valid, o_ready;
    logic [1:0]  i_memop, i_size;
    logic        i_unsigned;
    logic [31:0] i_exe_out, i_mem_wdata;
    logic [4:0]  i_rdest, o_rdest;
    logic        i_cu_regwrite, o_cu_regwrite;
    logic [1:0]  i_cu_memtoreg, o_cu_memtoreg;
    logic [31:0] i_pcplus4, o_pcplus4, o_exe_data, o_mem_data;
    logic        o_valid, o_exc_misaligned, o_mem_req, o_mem_we;
    logic [31:0] o_mem_addr, o_mem_wdata, i_mem_rdata;
    logic [3:0]  o_mem_be;
    logic        i_mem_gnt, i_mem_rvalid, o_sb_empty;

    logic gnt_en, rv_auto, rv_force;
    assign i_mem_gnt = o_mem_req & gnt_en;

    always #5 i_aclk = ~i_aclk;

    mem_access_sb dut (
        .i_aclk(i_aclk), .i_areset_n(i_areset_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_memop(i_memop), .i_size(i_size), .i_unsigned(i_unsigned), .i_exe_out(i_exe_out),
        .i_mem_wdata(i_mem_wdata), .i_rdest(i_rdest), .i_cu_regwrite(i_cu_regwrite),
        .i_cu_memtoreg(i_cu_memtoreg), .i_pcplus4(i_pcplus4), .o_valid(o_valid),
        .o_rdest(o_rdest), .o_cu_regwrite(o_cu_regwrite), .o_cu_memtoreg(o_cu_memtoreg),
        .o_pcplus4(o_pcplus4), .o_exe_data(o_exe_data), .o_mem_data(o_mem_data),
        .o_exc_misaligned(o_exc_misaligned), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
        .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
        .o_sb_empty(o_sb_empty)
    );

    typedef struct {
        logic [1:0]  memop, size;
        logic        uns;
        logic [31:0] addr, wdata;
        logic [4:0]  rd;
        logic        rw, pre;
        logic [31:0] pre_val;
        logic        exc;
        logic [31:0] data, wd;
        logic [3:0]  be;
    } vec_t;

    typedef struct packed {
        logic        exc, rw;
        logic [4:0]  rd;
        logic [1:0]  mtr;
        logic [31:0] pc, exe;
        logic        is_load;
        logic [31:0] data;
    } wb_t;

    typedef struct packed {
        logic [31:0] addr, wdata;
        logic [3:0]  be;
    } wr_t;

    wb_t         wb_q[$];
    wr_t         wr_q[$];
    logic [31:0] mem [logic [29:0]];
    int          n_chk = 0, n_fail = 0;
    logic        snap_req, snap_we, snap_empty, snap_ready;

    function automatic vec_t mk(input logic [1:0] memop, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                                input logic rw, input logic pre, input logic [31:0] pre_val,
                                input logic exc, input logic [31:0] data, input logic [31:0] wd,
                                input logic [3:0] be);
        vec_t v;
        v.memop = memop; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.rd = rd; v.rw = rw; v.pre = pre; v.pre_val = pre_val; v.exc = exc;
        v.data = data; v.wd = wd; v.be = be;
        return v;
    endfunction

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return mem.exists(a[31:2]) ? mem[a[31:2]] : 32'h0;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: sample and score at the falling edge, then act as memory after the rising edge.
    task automatic tick(output bit acc);
        wb_t e, a;
        wr_t w, wa;
        logic [31:0] old, paddr;
        logic pend;
        @(negedge i_aclk);
        acc = i_valid & o_ready;
        snap_req = o_mem_req; snap_we = o_mem_we; snap_empty = o_sb_empty; snap_ready = o_ready;
        if (o_valid) begin
            if (wb_q.size() == 0) check("unexpected_o_valid", o_valid, 0);
            else begin
                e = wb_q.pop_front();
                a.exc = o_exc_misaligned; a.rw = o_cu_regwrite; a.rd = o_rdest;
                a.mtr = o_cu_memtoreg; a.pc = o_pcplus4; a.exe = o_exe_data;
                a.is_load = e.is_load; a.data = e.is_load ? o_mem_data : 32'h0;
                check("wb_output", a, e);
            end
        end
        if (o_mem_req && i_mem_gnt && o_mem_we) begin
            wa.addr = o_mem_addr; wa.wdata = o_mem_wdata; wa.be = o_mem_be;
            if (wr_q.size() == 0) check("unexpected_write", o_mem_we, 0);
            else begin
                w = wr_q.pop_front();
                check("mem_write", wa, w);
            end
            old = rd_mem(o_mem_addr);
            for (int b = 0; b < 4; b++)
                if (o_mem_be[b]) old[8*b +: 8] = o_mem_wdata[8*b +: 8];
            mem[o_mem_addr[31:2]] = old;
        end
        pend  = o_mem_req & i_mem_gnt & ~o_mem_we & rv_auto;
        paddr = o_mem_addr;
        @(posedge i_aclk);
        #1;
        i_mem_rvalid = pend | rv_force;
        i_mem_rdata  = pend ? rd_mem(paddr) : 32'h0;
    endtask

    task automatic drive(input vec_t v, input int idx);
        i_valid = 1'b1; i_memop = v.memop; i_size = v.size; i_unsigned = v.uns;
        i_exe_out = v.addr; i_mem_wdata = v.wdata; i_rdest = v.rd; i_cu_regwrite = v.rw;
        i_cu_memtoreg = idx[1:0]; i_pcplus4 = 32'h1000 + 32'(4 * idx);
    endtask

    task automatic push_exp(input vec_t v, input int idx);
        wb_t e;
        wr_t w;
        e.exc = v.exc; e.rw = v.exc ? 1'b0 : v.rw; e.rd = v.rd; e.mtr = idx[1:0];
        e.pc = 32'h1000 + 32'(4 * idx); e.exe = v.addr;
        e.is_load = (v.memop == 2'b01) && !v.exc; e.data = e.is_load ? v.data : 32'h0;
        wb_q.push_back(e);
        if (v.memop == 2'b10 && !v.exc) begin
            w.addr = {v.addr[31:2], 2'b00}; w.wdata = v.wd; w.be = v.be;
            wr_q.push_back(w);
        end
    endtask

    task automatic idle_inputs();
        i_valid = 1'b0; i_memop = 2'b00;
    endtask

    task automatic apply(input vec_t v, input int idx);
        bit acc;
        int n;
        if (v.pre) mem[v.addr[31:2]] = v.pre_val;
        drive(v, idx);
        acc = 1'b0;
        n = 0;
        while (!acc && n < 60) begin
            tick(acc);
            n++;
        end
        idle_inputs();
        check("accepted", acc, 1);
        if (acc) push_exp(v, idx);
    endtask

    task automatic wait_idle(input string name);
        bit acc;
        int n;
        logic done;
        idle_inputs();
        n = 0;
        done = 1'b0;
        while (!done && n < 200) begin
            done = o_sb_empty && !o_mem_req && (wb_q.size() == 0) && (wr_q.size() == 0);
            if (!done) begin
                tick(acc);
                n++;
            end
        end
        check(name, done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[16];
        vec_t v;
        bit acc;

        tbl[0]  = mk(2'b10, 2'b00, 0, 32'h103, 32'h000000A5, 5'd0,  0, 0, 0, 0, 0, 32'hA5A5A5A5, 4'b1000);
        tbl[1]  = mk(2'b01, 2'b00, 0, 32'h103, 0, 5'd5,  1, 0, 0, 0, 32'hFFFFFFA5, 0, 0);
        tbl[2]  = mk(2'b01, 2'b00, 1, 32'h103, 0, 5'd6,  1, 0, 0, 0, 32'h000000A5, 0, 0);
        tbl[3]  = mk(2'b01, 2'b01, 1, 32'h302, 0, 5'd8,  1, 1, 32'h8001ABCD, 0, 32'h00008001, 0, 0);
        tbl[4]  = mk(2'b01, 2'b01, 0, 32'h302, 0, 5'd9,  1, 0, 0, 0, 32'hFFFF8001, 0, 0);
        tbl[5]  = mk(2'b01, 2'b00, 0, 32'h301, 0, 5'd10, 1, 0, 0, 0, 32'hFFFFFFAB, 0, 0);
        tbl[6]  = mk(2'b01, 2'b01, 1, 32'h300, 0, 5'd4,  1, 0, 0, 0, 32'h0000ABCD, 0, 0);
        tbl[7]  = mk(2'b10, 2'b01, 0, 32'h402, 32'h1234BEEF, 5'd0, 0, 0, 0, 0, 0, 32'hBEEFBEEF, 4'b1100);
        tbl[8]  = mk(2'b10, 2'b00, 0, 32'h401, 32'h00000077, 5'd0, 0, 0, 0, 0, 0, 32'h77777777, 4'b0010);
        tbl[9]  = mk(2'b01, 2'b10, 0, 32'h400, 0, 5'd11, 1, 0, 0, 0, 32'hBEEF7700, 0, 0);
        tbl[10] = mk(2'b01, 2'b01, 0, 32'h101, 0, 5'd12, 1, 0, 0, 1, 0, 0, 0);
        tbl[11] = mk(2'b01, 2'b10, 0, 32'h102, 0, 5'd13, 1, 0, 0, 1, 0, 0, 0);
        tbl[12] = mk(2'b10, 2'b11, 0, 32'h104, 32'h55, 5'd14, 1, 0, 0, 1, 0, 0, 0);
        tbl[13] = mk(2'b00, 2'b00, 0, 32'hABCD0001, 0, 5'd7, 1, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(2'b11, 2'b11, 0, 32'h00000003, 0, 5'd15, 1, 0, 0, 0, 0, 0, 0);
        tbl[15] = mk(2'b10, 2'b10, 0, 32'h106, 32'h12345678, 5'd16, 0, 0, 0, 1, 0, 0, 0);

        i_areset_n = 1'b0; gnt_en = 1'b1; rv_auto = 1'b1; rv_force = 1'b0;
        i_mem_rvalid = 1'b0; i_mem_rdata = 32'h0;
        i_unsigned = 1'b0; i_size = 2'b00; i_exe_out = 32'h0; i_mem_wdata = 32'h0;
        i_rdest = 5'd0; i_cu_regwrite = 1'b0; i_cu_memtoreg = 2'b00; i_pcplus4 = 32'h0;
        idle_inputs();
        #12;
        check("reset_state", {o_valid, o_mem_req, o_cu_regwrite, o_exc_misaligned, o_sb_empty, o_ready, o_mem_data},
              {6'b000011, 32'h0});
        @(posedge i_aclk);
        #1;
        i_areset_n = 1'b1;

        // Store then independent load: the load goes out ahead of the buffered store.
        apply(mk(2'b10, 2'b10, 0, 32'h100, 32'hDEADBEEF, 5'd1, 0, 0, 0, 0, 0, 32'hDEADBEEF, 4'b1111), 20);
        apply(mk(2'b01, 2'b10, 0, 32'h200, 0, 5'd3, 1, 1, 32'h12345678, 0, 32'h12345678, 0, 0), 21);
        tick(acc);
        check("load_before_drain", {snap_req, snap_we, snap_empty}, 3'b100);
        wait_idle("idle_after_t1");

        for (int i = 0; i < 16; i++) begin
            apply(tbl[i], i);
            if (tbl[i].exc) begin
                tick(acc);
                check("misaligned_no_req", snap_req, 0);
            end
        end
        wait_idle("idle_after_table");

        // Full buffer with the bus stalled, then a single grant cycle frees one slot.
        gnt_en = 1'b0;
        for (int i = 0; i < 4; i++)
            apply(mk(2'b10, 2'b10, 0, 32'h500 + 32'(4 * i), 32'h11110000 + 32'(i), 5'd0, 0, 0, 0, 0, 0,
                     32'h11110000 + 32'(i), 4'b1111), 30 + i);
        v = mk(2'b10, 2'b10, 0, 32'h510, 32'h22222222, 5'd2, 0, 0, 0, 0, 0, 32'h22222222, 4'b1111);
        drive(v, 34);
        for (int i = 0; i < 3; i++) tick(acc);
        check("full_blocks_store", {acc, snap_ready}, 2'b00);
        gnt_en = 1'b1;
        tick(acc);
        check("push_on_pop_full", acc, 1);
        if (acc) push_exp(v, 34);
        gnt_en = 1'b0;
        v = mk(2'b10, 2'b10, 0, 32'h514, 32'h33333333, 5'd2, 0, 0, 0, 0, 0, 32'h33333333, 4'b1111);
        drive(v, 35);
        tick(acc);
        check("still_full", {acc, snap_ready, snap_empty}, 3'b000);
        idle_inputs();
        if (acc) push_exp(v, 35);
        gnt_en = 1'b1;
        wait_idle("idle_after_full");

        // Reset between grant and read data; a late rvalid must be ignored.
        rv_auto = 1'b0;
        apply(mk(2'b01, 2'b10, 0, 32'h600, 0, 5'd9, 1, 1, 32'hCAFEF00D, 0, 32'hCAFEF00D, 0, 0), 40);
        tick(acc);
        check("load_granted", {snap_req, snap_we}, 2'b10);
        i_areset_n = 1'b0;
        wb_q.delete();
        tick(acc);
        check("in_reset", {o_valid, o_mem_req, o_sb_empty}, 3'b001);
        i_areset_n = 1'b1;
        rv_force = 1'b1;
        tick(acc);
        rv_force = 1'b0;
        tick(acc);
        check("post_reset_state", {o_valid, o_mem_req, o_cu_regwrite, o_exc_misaligned, o_sb_empty, o_ready},
              6'b000011);
        check("post_reset_data", {o_mem_data, 3'b000, o_rdest}, 40'h0);
        tick(acc);
        check("post_reset_no_valid", o_valid, 0);
        rv_auto = 1'b1;
        apply(mk(2'b01, 2'b10, 0, 32'h600, 0, 5'd21, 1, 0, 0, 0, 32'hCAFEF00D, 0, 0), 41);
        wait_idle("idle_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
